// File: rtl/lcd_link_sequencer.sv
// Display link power/command sequencer: OFF -> PWR_UP -> SETUP -> ACTIVATE -> ON -> SHUTDOWN -> PWR_DOWN.
// Optional macro LCD_SEQ_RETRY_EN adds bounded re-issue of a timed-out SETUP/ACTIVATE command.
module lcd_link_sequencer #(
  parameter int POWER_DELAY = 1000,
  parameter int CMD_TIMEOUT = 100000,
  parameter int TIMER_WIDTH = 20,
  parameter int MAX_RETRIES = 2
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_enable,
  input  logic       i_done,
  output logic       o_power_en,
  output logic       o_setup,
  output logic       o_activate,
  output logic       o_shutdown,
  output logic       o_ready,
  output logic       o_error,
  output logic [2:0] o_state
);

  typedef enum logic [2:0] {
    S_OFF      = 3'd0,
    S_PWR_UP   = 3'd1,
    S_SETUP    = 3'd2,
    S_ACTIVATE = 3'd3,
    S_ON       = 3'd4,
    S_SHUTDOWN = 3'd5,
    S_PWR_DOWN = 3'd6,
    S_ERROR    = 3'd7
  } state_t;

  localparam logic [TIMER_WIDTH-1:0] PWR_LAST = TIMER_WIDTH'(POWER_DELAY - 1);
  localparam logic [TIMER_WIDTH-1:0] CMD_LAST = TIMER_WIDTH'(CMD_TIMEOUT - 1);

  state_t                 state_reg;
  state_t                 state_next;
  logic [TIMER_WIDTH-1:0] timer_reg;
  logic                   off_req_reg;
  logic                   restart;
  logic                   entering;
  logic                   done_ok;
  logic                   timer_counting;
  logic                   retry_ok;

  // Timer is zero only in the strobe cycle, which masks a stale done left over from the last command.
  assign done_ok  = i_done && (timer_reg != '0);
  assign entering = (state_next != state_reg) || restart;
  assign o_state  = state_reg;

  assign timer_counting = (state_reg == S_PWR_UP) || (state_reg == S_SETUP) ||
                          (state_reg == S_ACTIVATE) || (state_reg == S_SHUTDOWN) ||
                          (state_reg == S_PWR_DOWN);

`ifdef LCD_SEQ_RETRY_EN
  localparam int RETRY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

  logic [RETRY_W-1:0] retry_reg;

  assign retry_ok = (retry_reg < RETRY_W'(MAX_RETRIES));

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      retry_reg <= '0;
    end else if (state_next == S_PWR_UP) begin
      retry_reg <= '0;
    end else if (restart) begin
      retry_reg <= retry_reg + 1'b1;
    end
  end
`else
  assign retry_ok = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    restart    = 1'b0;
    case (state_reg)
      S_OFF: begin
        if (i_enable) state_next = S_PWR_UP;
      end
      S_PWR_UP: begin
        if (!i_enable)               state_next = S_PWR_DOWN;
        else if (timer_reg == PWR_LAST) state_next = S_SETUP;
      end
      S_SETUP, S_ACTIVATE: begin
        if (done_ok) begin
          if (off_req_reg || !i_enable) state_next = S_SHUTDOWN;
          else if (state_reg == S_SETUP) state_next = S_ACTIVATE;
          else                           state_next = S_ON;
        end else if (timer_reg == CMD_LAST) begin
          if (retry_ok) restart    = 1'b1;
          else          state_next = S_ERROR;
        end
      end
      S_ON: begin
        if (!i_enable) state_next = S_SHUTDOWN;
      end
      S_SHUTDOWN: begin
        // A panel that never acknowledges shutdown is still powered down.
        if (done_ok || (timer_reg == CMD_LAST)) state_next = S_PWR_DOWN;
      end
      S_PWR_DOWN: begin
        if (timer_reg == PWR_LAST) state_next = S_OFF;
      end
      S_ERROR: begin
        if (!i_enable) state_next = S_OFF;
      end
      default: state_next = S_OFF;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_reg   <= S_OFF;
      timer_reg   <= '0;
      off_req_reg <= 1'b0;
      o_power_en  <= 1'b0;
      o_setup     <= 1'b0;
      o_activate  <= 1'b0;
      o_shutdown  <= 1'b0;
      o_ready     <= 1'b0;
      o_error     <= 1'b0;
    end else begin
      state_reg <= state_next;

      if (entering)
        timer_reg <= '0;
      else if (timer_counting && (timer_reg != '1))
        timer_reg <= timer_reg + 1'b1;

      // Once enable drops mid-command the power-on attempt is committed to shutting down.
      if (state_next == S_PWR_UP)
        off_req_reg <= 1'b0;
      else if (((state_reg == S_SETUP) || (state_reg == S_ACTIVATE)) && !i_enable)
        off_req_reg <= 1'b1;

      o_setup    <= entering && (state_next == S_SETUP);
      o_activate <= entering && (state_next == S_ACTIVATE);
      o_shutdown <= entering && (state_next == S_SHUTDOWN);
      o_power_en <= (state_next == S_PWR_UP) || (state_next == S_SETUP) ||
                    (state_next == S_ACTIVATE) || (state_next == S_ON) ||
                    (state_next == S_SHUTDOWN);
      o_ready    <= (state_next == S_ON);
      o_error    <= (state_next == S_ERROR);
    end
  end

endmodule

// File: tb/tb_lcd_link_sequencer.sv
// Directed bench for lcd_link_sequencer with POWER_DELAY=4, CMD_TIMEOUT=16, MAX_RETRIES=2.
module tb_lcd_link_sequencer;

  logic       clk;
  logic       i_reset;
  logic       i_enable;
  logic       i_done;
  logic       o_power_en;
  logic       o_setup;
  logic       o_activate;
  logic       o_shutdown;
  logic       o_ready;
  logic       o_error;
  logic [2:0] o_state;
  logic [5:0] outs;

  int vectors     = 0;
  int miscompares = 0;
  int strobes     = 0;

`ifdef LCD_SEQ_RETRY_EN
  localparam int ATTEMPTS = 3;
`else
  localparam int ATTEMPTS = 1;
`endif

  lcd_link_sequencer #(
    .POWER_DELAY(4),
    .CMD_TIMEOUT(16),
    .TIMER_WIDTH(8),
    .MAX_RETRIES(2)
  ) dut (
    .i_clock   (clk),
    .i_reset   (i_reset),
    .i_enable  (i_enable),
    .i_done    (i_done),
    .o_power_en(o_power_en),
    .o_setup   (o_setup),
    .o_activate(o_activate),
    .o_shutdown(o_shutdown),
    .o_ready   (o_ready),
    .o_error   (o_error),
    .o_state   (o_state)
  );

  // {power_en, setup, activate, shutdown, ready, error}
  assign outs = {o_power_en, o_setup, o_activate, o_shutdown, o_ready, o_error};

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("vec %0d %s = %0h", vectors, tag, got);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clk      = 1'b0;
    i_reset  = 1'b1;
    i_enable = 1'b0;
    i_done   = 1'b0;
    step(2);
    check("reset_state", 8'(o_state), 8'd0);
    check("reset_outs", 8'(outs), 8'h00);
    i_reset = 1'b0;
    step(1);
    check("idle_state", 8'(o_state), 8'd0);

    // Nominal power-up; done returned so the next state lands 5 cycles after each strobe.
    i_enable = 1'b1;                       // cycle 0
    step(1);                               // cycle 1
    check("c1_state", 8'(o_state), 8'd1);
    check("c1_outs", 8'(outs), 8'b100000);
    step(3);                               // cycle 4
    check("c4_state", 8'(o_state), 8'd1);
    step(1);                               // cycle 5
    check("c5_state", 8'(o_state), 8'd2);
    check("c5_outs", 8'(outs), 8'b110000);
    step(1);
    check("c6_outs", 8'(outs), 8'b100000);
    step(3);                               // cycle 9
    i_done = 1'b1;
    step(1);                               // cycle 10
    i_done = 1'b0;
    check("c10_state", 8'(o_state), 8'd3);
    check("c10_outs", 8'(outs), 8'b101000);
    step(4);                               // cycle 14
    check("c14_state", 8'(o_state), 8'd3);
    i_done = 1'b1;
    step(1);                               // cycle 15
    i_done = 1'b0;
    check("c15_state", 8'(o_state), 8'd4);
    check("c15_outs", 8'(outs), 8'b100010);

    // Power down from ON, with enable re-raised during the dwell.
    i_enable = 1'b0;
    step(1);
    check("shut_state", 8'(o_state), 8'd5);
    check("shut_outs", 8'(outs), 8'b100100);
    step(3);
    i_done = 1'b1;
    step(1);
    i_done   = 1'b0;
    i_enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("pdn_state_%0d", i), 8'(o_state), 8'd6);
      check($sformatf("pdn_outs_%0d", i), 8'(outs), 8'b000000);
      step(1);
    end
    check("pdn_off", 8'(o_state), 8'd0);
    step(1);
    check("repwr_state", 8'(o_state), 8'd1);

    // SETUP never acknowledged: timeout (with optional retries) into ERROR.
    step(4);
    check("to_setup_state", 8'(o_state), 8'd2);
    check("to_setup_strobe", 8'(o_setup), 8'd1);
    strobes = 1;
    for (int i = 1; i < 16 * ATTEMPTS; i++) begin
      step(1);
      strobes += int'(o_setup);
    end
    check("to_last_setup", 8'(o_state), 8'd2);
    step(1);
    check("to_err_state", 8'(o_state), 8'd7);
    check("to_err_outs", 8'(outs), 8'b000001);
    check("to_strobes", 8'(strobes), 8'(ATTEMPTS));
    i_enable = 1'b0;
    step(1);
    check("err_off_state", 8'(o_state), 8'd0);
    check("err_off_outs", 8'(outs), 8'b000000);

    // Done held high throughout: each command state lasts exactly two cycles.
    i_done   = 1'b1;
    i_enable = 1'b1;
    step(5);
    check("hd_setup1", 8'(o_state), 8'd2);
    check("hd_setup1_outs", 8'(outs), 8'b110000);
    step(1);
    check("hd_setup2", 8'(o_state), 8'd2);
    step(1);
    check("hd_act1", 8'(o_state), 8'd3);
    check("hd_act1_outs", 8'(outs), 8'b101000);
    step(1);
    check("hd_act2", 8'(o_state), 8'd3);
    step(1);
    check("hd_on", 8'(o_state), 8'd4);
    i_enable = 1'b0;
    step(1);
    check("hd_shut1_outs", 8'(outs), 8'b100100);
    step(1);
    check("hd_shut2", 8'(o_state), 8'd5);
    step(1);
    check("hd_pdn", 8'(o_state), 8'd6);
    i_done = 1'b0;
    step(3);
    check("hd_pdn_last", 8'(o_state), 8'd6);
    step(1);
    check("hd_off", 8'(o_state), 8'd0);

    // Enable dropped mid-SETUP: command completes, ACTIVATE is skipped.
    i_enable = 1'b1;
    step(5);
    check("ab_setup", 8'(o_state), 8'd2);
    step(1);
    i_enable = 1'b0;
    step(1);
    check("ab_hold_outs", 8'(outs), 8'b100000);
    i_done = 1'b1;
    step(1);
    i_done = 1'b0;
    check("ab_shut_state", 8'(o_state), 8'd5);
    check("ab_shut_outs", 8'(outs), 8'b100100);
    step(2);
    i_done = 1'b1;
    step(1);
    i_done = 1'b0;
    check("ab_pdn", 8'(o_state), 8'd6);
    step(4);
    check("ab_off", 8'(o_state), 8'd0);

    // Asynchronous reset while ON.
    i_enable = 1'b1;
    step(6);
    i_done = 1'b1;
    step(1);
    i_done = 1'b0;
    step(1);
    i_done = 1'b1;
    step(1);
    i_done = 1'b0;
    check("ar_on", 8'(o_state), 8'd4);
    #2 i_reset = 1'b1;
    #1;
    check("ar_state", 8'(o_state), 8'd0);
    check("ar_outs", 8'(outs), 8'b000000);
    @(negedge clk);
    i_reset  = 1'b0;
    i_enable = 1'b0;
    step(1);
    check("ar_after", 8'(o_state), 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/lcd_link_sequencer.md
Name: lcd_link_sequencer

Overview:
- Top-level sequencer for the display comms master: power-up, SETUP, ACTIVATE, steady ON, SHUTDOWN and power-down, in order.
- Issues one-cycle command strobes to the comms master and waits for its done flag, with a per-command timeout.
- Sits between system control (a level enable) and the comms master's i_setup / i_activate / i_shutdown / o_done interface.

Parameters:
- POWER_DELAY, 1000, cycles o_power_en must be high before SETUP is issued; also the minimum power-off dwell time.
- CMD_TIMEOUT, 100000, cycles allowed per command for i_done before the command fails.
- TIMER_WIDTH, 20, width of the shared delay/timeout counter; must satisfy 2^TIMER_WIDTH > max(POWER_DELAY, CMD_TIMEOUT).
- MAX_RETRIES, 2, extra attempts per command (used only with the optional feature).

Ports:
- i_clock  in  1  system clock.
- i_reset  in  1  asynchronous, active-high reset.
- i_enable  in  1  level request: 1 = display on, 0 = display off.
- i_done  in  1  comms master done flag.
- o_power_en  out  1  panel power rail enable.
- o_setup  out  1  one-cycle strobe to comms master i_setup.
- o_activate  out  1  one-cycle strobe to comms master i_activate.
- o_shutdown  out  1  one-cycle strobe to comms master i_shutdown.
- o_ready  out  1  high only in ON.
- o_error  out  1  high only in ERROR.
- o_state  out  3  current state encoding, for debug.

Behaviour:
- Reset:
  - State = OFF; timer = 0.
  - All outputs 0, o_state = 0.
  - Asserting i_reset mid-operation drops o_power_en immediately, with no shutdown command.
- All outputs are registered. State encodings: OFF=0, PWR_UP=1, SETUP=2, ACTIVATE=3, ON=4, SHUTDOWN=5, PWR_DOWN=6, ERROR=7.
- Timer: cleared on every state entry; increments each cycle while in PWR_UP, SETUP, ACTIVATE, SHUTDOWN and PWR_DOWN; saturates.
- Command strobes: o_setup, o_activate and o_shutdown are each high for exactly the first cycle spent in SETUP, ACTIVATE and SHUTDOWN respectively. At most one strobe is high in any cycle.
- Done detection: in a command state, i_done is honoured only from the second cycle in the state onward. i_done=1 in the strobe cycle is ignored, so a stale done from a previous command is not taken.
- Transitions:
  - OFF: i_enable=1 -> PWR_UP. o_power_en rises in the same edge.
  - PWR_UP: timer==POWER_DELAY-1 -> SETUP. If i_enable falls first -> PWR_DOWN.
  - SETUP: i_done -> ACTIVATE.
  - ACTIVATE: i_done -> ON.
  - ON: i_enable=0 -> SHUTDOWN.
  - SHUTDOWN: i_done -> PWR_DOWN. On timeout -> PWR_DOWN anyway; error is not flagged.
  - PWR_DOWN: o_power_en=0; timer==POWER_DELAY-1 -> OFF. i_enable is ignored during the dwell.
  - ERROR: o_power_en=0, o_error=1; i_enable=0 -> OFF.
- Command timeout in SETUP or ACTIVATE: timer==CMD_TIMEOUT-1 with no done -> ERROR.
- i_enable falling during SETUP or ACTIVATE:
  - the in-flight command is not aborted;
  - on its done, go to SHUTDOWN instead of the next state;
  - timeout still goes to ERROR.
- i_enable re-rising in SHUTDOWN or PWR_DOWN: the full off sequence completes first, then OFF, then PWR_UP on the next cycle.
- o_power_en is 1 in PWR_UP, SETUP, ACTIVATE, ON and SHUTDOWN; 0 elsewhere.
- Nominal latency from i_enable rising to o_ready: 1 + POWER_DELAY + t_setup + t_activate cycles, where t_x is cycles from strobe to accepted done.

Optional Feature:
- Macro: LCD_SEQ_RETRY_EN.
- Defined:
  - adds a retry counter, cleared on entry to PWR_UP;
  - a timeout in SETUP or ACTIVATE with retries < MAX_RETRIES increments it and re-enters the same state, which re-strobes the command and clears the timer;
  - once MAX_RETRIES is exhausted -> ERROR.
- Undefined: the first timeout goes straight to ERROR, and no retry counter is synthesised.

Test Plan (POWER_DELAY=4, CMD_TIMEOUT=16, MAX_RETRIES=2):
- Reset, then i_enable=1 at cycle 0; bench returns i_done 5 cycles after each strobe.
  - o_power_en=1 from cycle 1.
  - o_setup strobes at cycle 5; o_activate strobes 5 cycles later.
  - o_ready=1 the cycle after the second done.
  - o_state walks 0,1,2,3,4.
- From ON, drop i_enable.
  - o_shutdown strobes one cycle later.
  - After done: o_power_en=0 and o_ready=0 for exactly 4 cycles, then o_state=0.
  - Re-raising i_enable during PWR_DOWN has no effect until OFF.
- Never assert i_done after o_setup.
  - Macro undefined: o_state=7, o_error=1, o_power_en=0 exactly 16 cycles after entering SETUP.
  - Macro defined: 3 o_setup strobes total, then ERROR.
  - Dropping i_enable then returns to OFF.
- Hold i_done=1 continuously: the strobe-cycle done is ignored; each command state lasts exactly 2 cycles.
- Drop i_enable mid-SETUP and return i_done: ACTIVATE is skipped, and SHUTDOWN strobes on the cycle after done.
- Assert i_reset asynchronously (off-edge) while in ON: all outputs 0 and o_state=0 without waiting for a clock edge.
